// File: rtl/mult4u_result_checker.sv
// mult4u_result_checker
//   Downstream checker for 4-bit unsigned multipliers. It accepts an (A, B, P) transaction,
//   recomputes A*B with a 4-step shift-add engine, and reports the golden product, the XOR
//   syndrome against P and a mismatch bit. Saturating vector/error counters and a sticky
//   error flag track fault behaviour over many vectors.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   clr              synchronous clear of vec_count, err_count, err_flag
//   in_valid/ready   transaction handshake; in_a, in_b operands, in_p product under test
//   res_valid/ready  result handshake; res_expected, res_syndrome, res_mismatch
//   vec_count        vectors checked (saturating)
//   err_count        mismatching vectors (saturating)
//   err_flag         sticky mismatch indicator
module mult4u_result_checker #(
    parameter int unsigned CNT_W       = 16,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [7:0]       in_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_expected,
    output logic [7:0]       res_syndrome,
    output logic             res_mismatch,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [7:0]       p_q, p_d;
    logic [7:0]       acc_q, acc_d;
    logic [1:0]       step_q, step_d;
    logic [7:0]       res_expected_q, res_expected_d;
    logic [7:0]       res_syndrome_q, res_syndrome_d;
    logic             res_mismatch_q, res_mismatch_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_flag_q, err_flag_d;

    logic [7:0] partial;
    logic [7:0] acc_sum;
    logic       step_mismatch;

    assign in_ready     = (state_q == StIdle) && !(STOP_ON_ERR && err_flag_q);
    assign res_valid    = (state_q == StDone);
    assign res_expected = res_expected_q;
    assign res_syndrome = res_syndrome_q;
    assign res_mismatch = res_mismatch_q;
    assign vec_count    = vec_count_q;
    assign err_count    = err_count_q;
    assign err_flag     = err_flag_q;

    // One partial product per CALC cycle; a 4x4 product never exceeds 8 bits.
    assign partial       = b_q[step_q] ? ({4'b0000, a_q} << step_q) : 8'h00;
    assign acc_sum       = acc_q + partial;
    assign step_mismatch = ((acc_sum ^ p_q) != 8'h00);

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        p_d            = p_q;
        acc_d          = acc_q;
        step_d         = step_q;
        res_expected_d = res_expected_q;
        res_syndrome_d = res_syndrome_q;
        res_mismatch_d = res_mismatch_q;
        vec_count_d    = vec_count_q;
        err_count_d    = err_count_q;
        err_flag_d     = err_flag_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    p_d     = in_p;
                    acc_d   = 8'h00;
                    step_d  = 2'd0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d  = acc_sum;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d        = StDone;
                    res_expected_d = acc_sum;
                    res_syndrome_d = acc_sum ^ p_q;
                    res_mismatch_d = step_mismatch;
                    if (vec_count_q != CntMax) begin
                        vec_count_d = vec_count_q + CntOne;
                    end
                    if (step_mismatch && (err_count_q != CntMax)) begin
                        err_count_d = err_count_q + CntOne;
                    end
                    if (step_mismatch) begin
                        err_flag_d = 1'b1;
                    end
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // clr wins over a coincident DONE-entry update; res_* are unaffected.
        if (clr) begin
            vec_count_d = '0;
            err_count_d = '0;
            err_flag_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            a_q            <= 4'h0;
            b_q            <= 4'h0;
            p_q            <= 8'h00;
            acc_q          <= 8'h00;
            step_q         <= 2'd0;
            res_expected_q <= 8'h00;
            res_syndrome_q <= 8'h00;
            res_mismatch_q <= 1'b0;
            vec_count_q    <= '0;
            err_count_q    <= '0;
            err_flag_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            p_q            <= p_d;
            acc_q          <= acc_d;
            step_q         <= step_d;
            res_expected_q <= res_expected_d;
            res_syndrome_q <= res_syndrome_d;
            res_mismatch_q <= res_mismatch_d;
            vec_count_q    <= vec_count_d;
            err_count_q    <= err_count_d;
            err_flag_q     <= err_flag_d;
        end
    end

endmodule

// File: tb/tb_mult4u_result_checker.sv
module tb_mult4u_result_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       res_ready = 1'b0;
    logic [3:0] in_a = 4'h0;
    logic [3:0] in_b = 4'h0;
    logic [7:0] in_p = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_res_ready = 1'b0;

    // Main instance
    logic        in_ready, res_valid, res_mismatch, err_flag;
    logic [7:0]  res_expected, res_syndrome;
    logic [15:0] vec_count, err_count;
    // Saturation instance (CNT_W=2), same traffic as main
    logic        sat_in_ready, sat_res_valid, sat_res_mismatch, sat_err_flag;
    logic [7:0]  sat_res_expected, sat_res_syndrome;
    logic [1:0]  sat_vec_count, sat_err_count;
    // STOP_ON_ERR instance with its own valid/ready
    logic        s_in_ready, s_res_valid, s_res_mismatch, s_err_flag;
    logic [7:0]  s_res_expected, s_res_syndrome;
    logic [15:0] s_vec_count, s_err_count;

    always #5 clk = ~clk;

    mult4u_result_checker #(.CNT_W(16), .STOP_ON_ERR(1'b0)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_p(in_p), .res_valid(res_valid), .res_ready(res_ready),
        .res_expected(res_expected), .res_syndrome(res_syndrome), .res_mismatch(res_mismatch),
        .vec_count(vec_count), .err_count(err_count), .err_flag(err_flag)
    );

    mult4u_result_checker #(.CNT_W(2), .STOP_ON_ERR(1'b0)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_a(in_a), .in_b(in_b), .in_p(in_p), .res_valid(sat_res_valid),
        .res_ready(res_ready), .res_expected(sat_res_expected),
        .res_syndrome(sat_res_syndrome), .res_mismatch(sat_res_mismatch),
        .vec_count(sat_vec_count), .err_count(sat_err_count), .err_flag(sat_err_flag)
    );

    mult4u_result_checker #(.CNT_W(16), .STOP_ON_ERR(1'b1)) u_stop (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(s_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_p(in_p), .res_valid(s_res_valid),
        .res_ready(s_res_ready), .res_expected(s_res_expected),
        .res_syndrome(s_res_syndrome), .res_mismatch(s_res_mismatch),
        .vec_count(s_vec_count), .err_count(s_err_count), .err_flag(s_err_flag)
    );

    typedef struct {
        logic [7:0] prod;
        logic [7:0] syn;
        bit         counted;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;
    int model_vec = 0;
    int model_err = 0;
    bit model_flag = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop on every main result handshake.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.counted) begin
                    model_vec++;
                    if (mon_e.syn != 8'h00) begin
                        model_err++;
                        model_flag = 1'b1;
                    end
                end
                check("res_expected", 32'(res_expected), 32'(mon_e.prod));
                check("res_syndrome", 32'(res_syndrome), 32'(mon_e.syn));
                check("res_mismatch", 32'(res_mismatch), 32'(mon_e.syn != 8'h00));
                check("vec_count", 32'(vec_count), 32'(model_vec));
                check("err_count", 32'(err_count), 32'(model_err));
                check("err_flag", 32'(err_flag), 32'(model_flag));
                check("sat_vec_count", 32'(sat_vec_count), (model_vec > 3) ? 32'd3 : 32'(model_vec));
                check("sat_err_count", 32'(sat_err_count), (model_err > 3) ? 32'd3 : 32'(model_err));
                check("sat_res_expected", 32'(sat_res_expected), 32'(mon_e.prod));
            end
        end
    end

    // Called just after a posedge; returns just after the transfer edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p,
                        input bit counted);
        exp_t e;
        bit   got;
        in_a = a;
        in_b = b;
        in_p = p;
        in_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = in_ready;
        end
        if (!got) begin
            check("send_in_ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            e.prod    = 8'({4'h0, a} * {4'h0, b});
            e.syn     = e.prod ^ p;
            e.counted = counted;
            sb_q.push_back(e);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb_q.size() > 0; n++) @(negedge clk);
        if (sb_q.size() > 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_vec  = 0;
        model_err  = 0;
        model_flag = 1'b0;
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_expected", 32'(res_expected), 32'd0);
        check("rst_res_mismatch", 32'(res_mismatch), 32'd0);
        check("rst_vec_count", 32'(vec_count), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        @(posedge clk);
        #1;

        // Reset during the 2nd CALC cycle aborts; nothing counted
        send(4'd5, 4'd3, 8'd15, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_vec_count", 32'(vec_count), 32'd0);
        check("abort_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;

        // Latency: result valid only after the 4th edge following transfer
        res_ready = 1'b0;
        send(4'd15, 4'd15, 8'hE1, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check("lat_res_valid", 32'(res_valid), 32'(i == 4));
            check("lat_in_ready", 32'(in_ready), 32'd0);
        end
        check("lat_res_expected", 32'(res_expected), 32'hE1);
        res_ready = 1'b1;
        drain();

        // Mismatching product
        send(4'd15, 4'd15, 8'hE0, 1'b1);
        drain();

        // Back-pressure: outputs stable, new input ignored
        res_ready = 1'b0;
        send(4'd0, 4'd9, 8'h00, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = res_valid;
        end
        if (!seen) check("stall_res_valid_timeout", 32'd0, 32'd1);
        in_a = 4'd7;
        in_b = 4'd7;
        in_p = 8'h55;
        in_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("stall_res_valid", 32'(res_valid), 32'd1);
            check("stall_res_expected", 32'(res_expected), 32'd0);
            check("stall_res_syndrome", 32'(res_syndrome), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        res_ready = 1'b1;
        drain();
        @(negedge clk);
        check("idle_hold_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // clr on the DONE-entry edge: vector not counted, result still presented
        res_ready = 1'b0;
        send(4'd3, 4'd5, 8'd15, 1'b0);
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_vec  = 0;
        model_err  = 0;
        model_flag = 1'b0;
        @(negedge clk);
        check("clr_done_res_valid", 32'(res_valid), 32'd1);
        check("clr_done_res_expected", 32'(res_expected), 32'd15);
        check("clr_done_vec_count", 32'(vec_count), 32'd0);
        check("clr_done_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1 res_ready = 1'b1;
        drain();

        // Saturation with CNT_W=2
        do_clr();
        for (int i = 0; i < 5; i++) send(4'd15, 4'd15, 8'h00, 1'b1);
        drain();
        check("sat_final_vec", 32'(sat_vec_count), 32'd3);
        check("sat_final_err", 32'(sat_err_count), 32'd3);
        check("main_final_err", 32'(err_count), 32'd5);

        // STOP_ON_ERR instance
        in_a = 4'd15;
        in_b = 4'd15;
        in_p = 8'h00;
        s_res_ready = 1'b1;
        s_valid = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = s_res_valid;
        end
        if (!seen) check("stop_res_valid_timeout", 32'd0, 32'd1);
        check("stop_mismatch", 32'(s_res_mismatch), 32'd1);
        @(posedge clk);
        #1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("stop_in_ready_blocked", 32'(s_in_ready), 32'd0);
            check("stop_err_flag", 32'(s_err_flag), 32'd1);
        end
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        in_p = 8'hE1;
        model_vec  = 0;
        model_err  = 0;
        model_flag = 1'b0;
        @(negedge clk);
        check("stop_in_ready_after_clr", 32'(s_in_ready), 32'd1);
        @(posedge clk);
        #1 s_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = s_res_valid;
        end
        check("stop_reaccept_valid", 32'(seen), 32'd1);
        check("stop_reaccept_mismatch", 32'(s_res_mismatch), 32'd0);
        check("stop_reaccept_vec", 32'(s_vec_count), 32'd1);
        @(posedge clk);
        #1;

        // Exhaustive correct products
        do_clr();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                send(4'(a), 4'(b), 8'(a * b), 1'b1);
            end
        end
        drain();
        check("exh_vec_count", 32'(vec_count), 32'd256);
        check("exh_err_count", 32'(err_count), 32'd0);
        check("exh_err_flag", 32'(err_flag), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
